branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences branch resolution in EX. Enables the branch comparator for branch instructions, combines its
//  taken result with the fetch-time prediction, and detects mispredicts. On a mispredict it flushes IF/ID
//  and holds a redirect PC to fetch under valid/ready. Owns the 2-bit branch history table (BHT) that fetch reads.
// PARAMETERS
//  BHT_ENTRIES  64  BHT depth; power of two, >=4; index = pc[$clog2(BHT_ENTRIES)+1:2]
//  CNT_W        16  width of mispredict event counter
// PORTS
//  clk             in   1      core clock
//  rst_n           in   1      asynchronous active-low reset
//  ex_valid        in   1      valid instruction in EX
//  ex_is_branch    in   1      EX instr is conditional branch (BEQ..BGEU)
//  ex_is_jump      in   1      EX instr is JAL/JALR (always taken)
//  ex_pc           in   32     PC of EX instr (RV32Consts::IntReg)
//  ex_target       in   32     computed branch/jump target
//  ex_pred_taken   in   1      prediction carried down pipe from fetch
//  bu_en           out  1      enable to branch comparator
//  bu_token        in   1      comparator result, same cycle as bu_en
//  if_pc           in   32     fetch PC for BHT lookup
//  if_pred_taken   out  1      BHT prediction for if_pc (combinational read)
//  flush_if_id     out  1      kill IF and ID stage contents
//  stall_ex        out  1      hold EX and older stages
//  redirect_valid  out  1      redirect request to fetch
//  redirect_pc     out  32     new fetch PC
//  redirect_ready  in   1      fetch accepts redirect
//  mispredict_cnt  out  CNT_W  mispredicts since reset, wraps
// BEHAVIOUR
//  Reset (async): state=IDLE; redirect_valid=0; redirect_pc=0; mispredict_cnt=0; all BHT entries=2'b01 (weak NT).
//  Resolve condition: resolve = ex_valid & (ex_is_branch|ex_is_jump) & state==IDLE.
//   When resolve=0, bu_en=0; the comparator then forces token=0.
//  bu_en = resolve & ex_is_branch.
//  actual_taken = ex_is_jump | bu_token.
//  next_pc = actual_taken ? ex_target : ex_pc+4 (mod 2^32).
//  mispredict = resolve & (actual_taken != ex_pred_taken).
//  Mispredict cycle:
//   - flush_if_id=1 combinationally.
//   - On the clock edge: redirect_pc<=next_pc; redirect_valid<=1; mispredict_cnt++; state->REDIRECT.
//  REDIRECT:
//   - redirect_valid=1, stall_ex=1, flush_if_id=1 (wrong-path fetches are discarded).
//   - The redirect handshake completes when redirect_valid & redirect_ready.
//   - On handshake: redirect_valid<=0; state->IDLE.
//   - Latency: earliest handshake is 1 cycle after the mispredict cycle; ready already high is accepted immediately.
//   - ex_valid is ignored in REDIRECT; the held EX instruction resolves after returning to IDLE
//     (it is the instr already resolved only if upstream failed to advance; EX must advance on the mispredict cycle).
//  Correct prediction: no flush, no stall, state stays IDLE.
//  A correctly predicted branch may resolve every cycle.
//  BHT update: on resolve & ex_is_branch, entry[idx(ex_pc)] saturates +1 if actual_taken, else -1.
//   - Bounds: 2'b11 stays on taken; 2'b00 stays on not-taken.
//   - Jumps do not update the BHT.
//  if_pred_taken = entry[idx(if_pc)][1].
//   - If if_pc and ex_pc hit the same index in the same cycle, the read returns the pre-update value.
//  mispredict_cnt wraps from all-ones to 0.
//  rst_n asserted mid-REDIRECT: redirect is dropped and all reset values apply at once.
// CONFIGURATION
//  BRANCH_PREDICT_EN defined:
//   - BHT is instantiated as above.
//  BRANCH_PREDICT_EN undefined:
//   - No BHT storage; if_pred_taken=0 (static not-taken).
//   - Mispredict = actual_taken.
//   - Every other behaviour is unchanged.
// STRUCTURE
//  Package BranchCtrlPkg:
//   - State enum {IDLE, REDIRECT}
//   - typedef Bht2b logic[1:0]
//   - constants BHT_RESET=2'b01, PC_STEP=4
//   - function sat_update(Bht2b, logic taken)
//  Sub-module branch_history_table (params BHT_ENTRIES):
//   - one async read port, one sync write port, async reset
//   - instantiated only under BRANCH_PREDICT_EN
// TESTING
//  1. Reset, then BEQ at pc=0x100:
//     - pred=0, token=0 -> no flush, no redirect, BHT[0x40&63]=00, mispredict_cnt=0.
//  2. BNE at pc=0x200, pred=0, token=1, target=0x80:
//     - flush_if_id=1 that cycle; next cycle redirect_valid=1, redirect_pc=0x80, cnt=1.
//  3. Case 2 with redirect_ready held low 3 cycles:
//     - redirect_valid, stall_ex, flush_if_id stay high; on ready=1 one handshake, then IDLE.
//  4. JAL at pc=0xFFFFFFFC, pred=1, target=0x10 -> no mispredict, BHT unchanged.
//     Then BLT at pc=0xFFFFFFFC, pred=1, token=0 -> redirect_pc=0x00000000 (wrap).
//  5. Four taken BGE at pc=0x40, if_pc=0x40 each cycle:
//     - if_pred_taken sequence 0,1,1,1 (old-value read); counter saturates at 11.
//  6. rst_n low during REDIRECT -> redirect_valid=0 immediately, state IDLE, cnt=0.
//     Also check build without BRANCH_PREDICT_EN: if_pred_taken always 0.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller.
// Build option: BRANCH_PREDICT_EN selects the 2-bit BHT predictor (else static not-taken).
package branch_resolve_ctrl_pkg;

    // Controller state: IDLE resolves branches, REDIRECT holds a redirect until fetch takes it
    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_e;

    // One 2-bit saturating history counter; bit 1 is the taken prediction
    typedef logic [1:0] bht2b_t;

    localparam bht2b_t      BHT_RESET = 2'b01;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Saturating counter step: 11 holds on taken, 00 holds on not-taken
    function automatic bht2b_t sat_update(input bht2b_t cur, input logic taken);
        bht2b_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_bht.sv
// Branch history table: 2-bit counters, one async read port for fetch,
// one synchronous saturating-update port for EX. A same-index read and
// update in one cycle returns the value from before the update.
module branch_history_table
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    localparam int IDX_W = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bht2b_t           rd_data,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht2b_t mem [BHT_ENTRIES];

    // Saturating update of the resolved entry; reset puts every entry at weak not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                mem[i] <= BHT_RESET;
            end
        end else if (upd_en) begin
            mem[upd_idx] <= sat_update(mem[upd_idx], upd_taken);
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: drives the comparator, detects mispredicts,
// flushes IF/ID and offers a redirect PC to fetch under valid/ready.
// Build option: BRANCH_PREDICT_EN instantiates the BHT; without it fetch
// always predicts not-taken and every taken branch/jump is a mispredict.
//
// Redirect handshake: redirect_valid rises the cycle after a mispredict and
// stays high with redirect_pc stable until a cycle where redirect_ready is
// also high; that cycle is the transfer and valid drops on the next edge.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    output logic             bu_en,
    input  logic             bu_token,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    output logic             flush_if_id,
    output logic             stall_ex,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic [CNT_W-1:0] mispredict_cnt,
    output state_e           state_dbg
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    state_e      state;
    logic        resolve;
    logic        actual_taken;
    logic        mispredict;
    logic [31:0] next_pc;

    assign resolve      = ex_valid & (ex_is_branch | ex_is_jump) & (state == IDLE);
    assign bu_en        = resolve & ex_is_branch;
    // Comparator output only counts while it is enabled
    assign actual_taken = ex_is_jump | (bu_en & bu_token);
    assign next_pc      = actual_taken ? ex_target : (ex_pc + PC_STEP);

`ifdef BRANCH_PREDICT_EN
    bht2b_t rd_cnt;
    logic   unused_if_pc;

    assign mispredict    = resolve & (actual_taken != ex_pred_taken);
    assign if_pred_taken = rd_cnt[1];
    // Only the index bits of the fetch PC select an entry
    assign unused_if_pc  = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    branch_history_table #(
        .BHT_ENTRIES(BHT_ENTRIES)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_data   (rd_cnt),
        .upd_en    (bu_en),
        .upd_idx   (ex_pc[IDX_W+1:2]),
        .upd_taken (actual_taken)
    );
`else
    logic unused_pred_inputs;

    // Static not-taken: any taken branch or jump was mispredicted
    assign mispredict         = resolve & actual_taken;
    assign if_pred_taken      = 1'b0;
    assign unused_pred_inputs = ^{if_pc, ex_pred_taken};
`endif

    assign flush_if_id = mispredict | (state == REDIRECT);
    assign stall_ex    = (state == REDIRECT);
    assign state_dbg   = state;

    // Redirect FSM: capture the corrected PC on a mispredict, hold it until fetch accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            mispredict_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        redirect_pc    <= next_pc;
                        redirect_valid <= 1'b1;
                        mispredict_cnt <= mispredict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        state          <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Testbench for branch_resolve_ctrl: directed scenarios plus random traffic
// checked against a behavioural model (integer counters, a redirect flag and
// an expected-redirect queue).
module tb_branch_resolve_ctrl;
    import branch_resolve_ctrl_pkg::*;

    localparam int ENTRIES = 64;
    localparam int CNT_W   = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             ex_valid, ex_is_branch, ex_is_jump, ex_pred_taken;
    logic [31:0]      ex_pc, ex_target, if_pc;
    logic             bu_en, bu_token, if_pred_taken, flush_if_id, stall_ex;
    logic             redirect_valid, redirect_ready;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] mispredict_cnt;
    state_e           state_dbg;

    branch_resolve_ctrl #(.BHT_ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .bu_en(bu_en), .bu_token(bu_token),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .flush_if_id(flush_if_id), .stall_ex(stall_ex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .mispredict_cnt(mispredict_cnt),
        .state_dbg(state_dbg)
    );

    // ---------------- reference model / scoreboard ----------------
    int               n_checks = 0;
    int               n_errors = 0;
    logic [31:0]      exp_q[$];
    int               bht_m[ENTRIES];
    bit               m_redirect;
    logic [31:0]      m_rpc;
    logic [CNT_W-1:0] m_cnt;
    bit               pe;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & (ENTRIES - 1));
    endfunction

    task automatic model_reset();
        m_redirect = 1'b0;
        m_rpc      = 32'h0;
        m_cnt      = '0;
        foreach (bht_m[i]) bht_m[i] = 1;
        exp_q.delete();
    endtask

    task automatic check_all(input bit e_bu_en, input bit e_flush, input bit e_ifp);
        check("bu_en", 32'(bu_en), 32'(e_bu_en));
        check("flush_if_id", 32'(flush_if_id), 32'(e_flush));
        check("stall_ex", 32'(stall_ex), 32'(m_redirect));
        check("redirect_valid", 32'(redirect_valid), 32'(m_redirect));
        check("redirect_pc", redirect_pc, m_rpc);
        check("mispredict_cnt", 32'(mispredict_cnt), 32'(m_cnt));
        check("if_pred_taken", 32'(if_pred_taken), 32'(e_ifp));
        check("state", 32'(state_dbg), m_redirect ? 32'(REDIRECT) : 32'(IDLE));
    endtask

    // ---------------- drivers ----------------
    task automatic drive_idle();
        ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_pred_taken = 0;
        ex_pc = 0; ex_target = 0; bu_token = 0; if_pc = 0; redirect_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        #1;
        check_all(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, check outputs, advance model at posedge
    task automatic step(input bit v, input bit br, input bit jmp,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input bit pred, input bit tok,
                        input logic [31:0] ipc, input bit rdy);
        bit resolve, actual, mis, e_ifp;
        logic [31:0] npc;
        int c;
        @(negedge clk);
        resolve = v && (br || jmp) && !m_redirect;
        if (!(resolve && br)) tok = 1'b0;
        ex_valid = v; ex_is_branch = br; ex_is_jump = jmp; ex_pc = pc;
        ex_target = tgt; ex_pred_taken = pred; bu_token = tok;
        if_pc = ipc; redirect_ready = rdy;
        actual = jmp || tok;
        npc    = actual ? tgt : pc + 32'd4;
        mis    = resolve && (pe ? (actual != pred) : actual);
        e_ifp  = pe && (bht_m[idx_of(ipc)] >= 2);
        #1;
        check_all(resolve && br, mis || m_redirect, e_ifp);
        if (m_redirect && rdy && exp_q.size() != 0)
            check("sb_redirect_pc", redirect_pc, exp_q.pop_front());
        @(posedge clk);
        if (m_redirect) begin
            if (rdy) m_redirect = 1'b0;
        end else if (mis) begin
            m_redirect = 1'b1;
            m_rpc      = npc;
            m_cnt      = m_cnt + 1'b1;
            exp_q.push_back(npc);
        end
        if (pe && resolve && br) begin
            c = bht_m[idx_of(pc)];
            bht_m[idx_of(pc)] = actual ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
`ifdef BRANCH_PREDICT_EN
        pe = 1'b1;
`else
        pe = 1'b0;
`endif
        drive_idle();
        model_reset();

        // 1: correctly predicted not-taken BEQ
        do_reset();
        step(1, 1, 0, 32'h100, 32'h500, 0, 0, 32'h100, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h100, 0);

        // 2: taken BNE predicted not-taken -> redirect to 0x80
        do_reset();
        step(1, 1, 0, 32'h200, 32'h80, 0, 1, 32'h0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
        #1;
        check("t2_redirect_pc", redirect_pc, 32'h80);
        check("t2_cnt", 32'(mispredict_cnt), 32'd1);

        // 3: same mispredict, fetch stalls ready for 3 cycles (EX keeps offering a branch)
        do_reset();
        step(1, 1, 0, 32'h200, 32'h80, 0, 1, 32'h0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h204, 32'h90, 0, 1, 32'h0, 0);
        step(1, 1, 0, 32'h204, 32'h90, 0, 1, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1);

        // 4: JAL at top of address space, then BLT falling through to wrap
        do_reset();
        step(1, 0, 1, 32'hFFFF_FFFC, 32'h10, 1, 0, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'hFFFF_FFFC, 1);
        step(1, 1, 0, 32'hFFFF_FFFC, 32'h10, 1, 0, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'hFFFF_FFFC, 1);

        // 5: back-to-back taken BGE at 0x40 with fetch reading the same entry
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h40, 32'h20, 1, 1, 32'h40, 1);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h40, 1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc, ipc;
            int kind;
            bit pred;
            kind = $urandom_range(0, 5);
            pc   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                               : 32'($urandom_range(0, 7) << 2);
            ipc  = ($urandom_range(0, 1) == 0) ? pc : 32'($urandom_range(0, 7) << 2);
            pred = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1))
                                               : (pe && bht_m[idx_of(pc)] >= 2);
            step($urandom_range(0, 3) != 0, kind <= 3, kind == 4, pc, $urandom,
                 pred, 1'($urandom_range(0, 1)), ipc, 1'($urandom_range(0, 1)));
        end

        // 6: reset while a redirect is pending
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
        step(1, 1, 0, 32'h300, 32'h44, 0, 1, 32'h0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        do_reset();
        step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
